// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: expands one LM/SM (register mask + base address) into
// one register transfer per cycle with contiguous addresses, holding decode while busy.
module lsm_sequencer #(
    parameter int unsigned NREG   = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      is_store,
    input  logic                      dir,
    input  logic [NREG-1:0]           mask,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      busy,
    output logic                      uop_valid,
    output logic [$clog2(NREG)-1:0]   uop_reg,
    output logic [ADDR_W-1:0]         uop_addr,
    output logic                      uop_is_store,
    output logic                      uop_last,
    output logic                      done
);

    localparam int unsigned RIDX_W = $clog2(NREG);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e              state_q, state_d;
    logic [NREG-1:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dir_q, dir_d;
    logic                st_q, st_d;
    logic                done_q, done_d;

    logic [RIDX_W-1:0]   sel_idx;
    logic [NREG-1:0]     sel_bit;
    logic                is_last;
    logic                issuing;

    // Lowest set bit when ascending, highest when descending; later loop hits win.
    always_comb begin
        sel_idx = '0;
        if (dir_q) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (rem_q[i]) sel_idx = RIDX_W'(i);
            end
        end else begin
            for (int i = int'(NREG) - 1; i >= 0; i--) begin
                if (rem_q[i]) sel_idx = RIDX_W'(i);
            end
        end
    end

    assign sel_bit = NREG'(1) << sel_idx;
    assign is_last = (rem_q != '0) && ((rem_q & (rem_q - NREG'(1))) == '0);
    assign issuing = (state_q == StIssue);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        st_d    = st_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = StIdle;
            rem_d   = '0;
        end else if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (mask != '0) begin
                            rem_d   = mask;
                            addr_d  = base_addr;
                            dir_d   = dir;
                            st_d    = is_store;
                            state_d = StIssue;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StIssue: begin
                    rem_d  = rem_q & ~sel_bit;
                    addr_d = dir_q ? (addr_q - ADDR_W'(STRIDE)) : (addr_q + ADDR_W'(STRIDE));
                    if (is_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // A stall lets done_q fall so the pulse is never stretched.
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            st_q    <= st_d;
            done_q  <= done_d;
        end
    end

    assign busy         = issuing;
    assign uop_valid    = issuing;
    assign uop_reg      = issuing ? sel_idx : '0;
    assign uop_addr     = issuing ? addr_q : '0;
    assign uop_is_store = issuing & st_q;
    assign uop_last     = issuing & is_last;
    assign done         = done_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: default 8-register build plus a 16-register,
// 32-bit-address build, checked cycle by cycle against hand-computed vectors.
module tb_lsm_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic        start = 0, is_store = 0, dir = 0, stall = 0, flush = 0;
    logic [7:0]  mask = '0;
    logic [15:0] base_addr = '0;
    logic        busy, uop_valid, uop_is_store, uop_last, done;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;

    logic        b_start = 0, b_is_store = 0, b_dir = 0, b_stall = 0, b_flush = 0;
    logic [15:0] b_mask = '0;
    logic [31:0] b_base_addr = '0;
    logic        b_busy, b_uop_valid, b_uop_is_store, b_uop_last, b_done;
    logic [3:0]  b_uop_reg;
    logic [31:0] b_uop_addr;

    int checks = 0;
    int errors = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    lsm_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store), .dir(dir),
        .mask(mask), .base_addr(base_addr), .stall(stall), .flush(flush), .busy(busy),
        .uop_valid(uop_valid), .uop_reg(uop_reg), .uop_addr(uop_addr),
        .uop_is_store(uop_is_store), .uop_last(uop_last), .done(done)
    );

    lsm_sequencer #(.NREG(16), .ADDR_W(32), .STRIDE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .is_store(b_is_store), .dir(b_dir),
        .mask(b_mask), .base_addr(b_base_addr), .stall(b_stall), .flush(b_flush),
        .busy(b_busy), .uop_valid(b_uop_valid), .uop_reg(b_uop_reg), .uop_addr(b_uop_addr),
        .uop_is_store(b_uop_is_store), .uop_last(b_uop_last), .done(b_done)
    );

    // Packed {busy, valid, reg, addr, is_store, last, done}
    function automatic logic [63:0] pa(logic b, logic v, logic [2:0] r, logic [15:0] a,
                                       logic s, logic l, logic d);
        return {40'b0, b, v, r, a, s, l, d};
    endfunction

    function automatic logic [63:0] pb(logic b, logic v, logic [3:0] r, logic [31:0] a,
                                       logic s, logic l, logic d);
        return {23'b0, b, v, r, a, s, l, d};
    endfunction

    function automatic logic [63:0] obs_a();
        return pa(busy, uop_valid, uop_reg, uop_addr, uop_is_store, uop_last, done);
    endfunction

    function automatic logic [63:0] obs_b();
        return pb(b_busy, b_uop_valid, b_uop_reg, b_uop_addr, b_uop_is_store, b_uop_last,
                  b_done);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
    endtask

    initial begin
        logic [15:0] a;
        busy_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        chk("reset_b", obs_b(), pb(0, 0, 0, 32'h0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Ascending LM, then a descending SM started in the done cycle
        start = 1; dir = 0; is_store = 0; mask = 8'hA4; base_addr = 16'h0010;
        tick(); start = 0;
        chk("s1_r2", obs_a(), pa(1, 1, 2, 16'h0010, 0, 0, 0));
        tick(); chk("s1_r5", obs_a(), pa(1, 1, 5, 16'h0011, 0, 0, 0));
        tick(); chk("s1_r7", obs_a(), pa(1, 1, 7, 16'h0012, 0, 1, 0));
        tick(); chk("s1_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));
        start = 1; dir = 1; is_store = 1; mask = 8'hA4; base_addr = 16'h0010;
        tick(); start = 0;
        chk("s2_r7", obs_a(), pa(1, 1, 7, 16'h0010, 1, 0, 0));
        tick(); chk("s2_r5", obs_a(), pa(1, 1, 5, 16'h000F, 1, 0, 0));
        tick(); chk("s2_r2", obs_a(), pa(1, 1, 2, 16'h000E, 1, 1, 0));
        tick(); chk("s2_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));
        tick(); chk("s2_idle", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));

        // Full mask with address wrap
        start = 1; dir = 0; is_store = 0; mask = 8'hFF; base_addr = 16'hFFFE;
        tick(); start = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'hFFFE + 16'(i);
            chk($sformatf("s3_r%0d", i), obs_a(), pa(1, 1, 3'(i), a, 0, i == 7, 0));
            tick();
        end
        chk("s3_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));
        tick();

        // Stall for three cycles on the second transfer
        start = 1; mask = 8'h0F; base_addr = 16'h0020;
        busy_cnt = 0;
        tick(); start = 0;
        chk("s4_r0", obs_a(), pa(1, 1, 0, 16'h0020, 0, 0, 0));
        tick(); chk("s4_r1a", obs_a(), pa(1, 1, 1, 16'h0021, 0, 0, 0));
        stall = 1;
        tick(); chk("s4_r1b", obs_a(), pa(1, 1, 1, 16'h0021, 0, 0, 0));
        tick(); chk("s4_r1c", obs_a(), pa(1, 1, 1, 16'h0021, 0, 0, 0));
        tick(); chk("s4_r1d", obs_a(), pa(1, 1, 1, 16'h0021, 0, 0, 0));
        stall = 0;
        tick(); chk("s4_r2", obs_a(), pa(1, 1, 2, 16'h0022, 0, 0, 0));
        tick(); chk("s4_r3", obs_a(), pa(1, 1, 3, 16'h0023, 0, 1, 0));
        tick(); chk("s4_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));
        chk("s4_busy_cycles", 64'(busy_cnt), 64'd7);
        tick(); chk("s4_one_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));

        // Flush during the second transfer
        start = 1; mask = 8'hF0; base_addr = 16'h0040;
        tick(); start = 0;
        chk("s5_r4", obs_a(), pa(1, 1, 4, 16'h0040, 0, 0, 0));
        tick(); chk("s5_r5", obs_a(), pa(1, 1, 5, 16'h0041, 0, 0, 0));
        flush = 1;
        tick(); flush = 0;
        chk("s5_flushed", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        tick(); chk("s5_no_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        start = 1; flush = 1; mask = 8'hFF;
        tick(); start = 0; flush = 0;
        chk("s5_start_flushed", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        start = 1; mask = 8'h00;
        tick(); start = 0;
        chk("s5_empty_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));
        tick(); chk("s5_empty_after", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));

        // Asynchronous reset mid-sequence, then a clean restart
        start = 1; mask = 8'h0F; base_addr = 16'h0030;
        tick(); start = 0;
        chk("s6_r0", obs_a(), pa(1, 1, 0, 16'h0030, 0, 0, 0));
        #2 reset_n = 0;
        #1 chk("s6_async_reset", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1;
        tick(); chk("s6_after_reset", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 0));
        start = 1; mask = 8'hA4; base_addr = 16'h0010; dir = 0;
        tick(); start = 0;
        chk("s6_r2", obs_a(), pa(1, 1, 2, 16'h0010, 0, 0, 0));
        tick(); chk("s6_r5", obs_a(), pa(1, 1, 5, 16'h0011, 0, 0, 0));
        tick(); chk("s6_r7", obs_a(), pa(1, 1, 7, 16'h0012, 0, 1, 0));
        tick(); chk("s6_done", obs_a(), pa(0, 0, 0, 16'h0, 0, 0, 1));

        // Wide build: 16 registers, 32-bit addresses
        b_start = 1; b_mask = 16'h80A4; b_base_addr = 32'h0000_0010;
        tick(); b_start = 0;
        chk("w_r2", obs_b(), pb(1, 1, 2, 32'h10, 0, 0, 0));
        tick(); chk("w_r5", obs_b(), pb(1, 1, 5, 32'h11, 0, 0, 0));
        tick(); chk("w_r7", obs_b(), pb(1, 1, 7, 32'h12, 0, 0, 0));
        tick(); chk("w_r15", obs_b(), pb(1, 1, 15, 32'h13, 0, 1, 0));
        tick(); chk("w_done", obs_b(), pb(0, 0, 0, 32'h0, 0, 0, 1));
        tick(); chk("w_idle", obs_b(), pb(0, 0, 0, 32'h0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
